pipe_d_stage: RTL

Parametrised IF/ID pipeline stage for the pipelined MIPS CPU. It registers the fetched PC+4 and instruction, and holds both on a stall. A flush squashes the stage into a NOP bubble, and a valid bit tracks real instructions. From the registered values it produces the decoded fields, the branch/jump targets and the control-transfer flags for the ID stage. Optional saturating stall/flush counters support performance analysis.

---
 rtl/pipe_d_stage_if.sv | 44 ++++
 rtl/pipe_d_stage.sv | 101 ++++++++++
 2 files changed

// File: rtl/pipe_d_stage_if.sv
// IF/ID stage bundle: IF-side controls in, decoded ID-side view out.
// The producer (IF/hazard unit) holds the master modport, the stage holds the slave.
interface pipe_d_stage_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic [PC_W-1:0]  pc4;
  logic [31:0]      ins;
  logic             fvalid;
  logic             wpcir;
  logic             dflush;
  logic             cnt_clr;

  logic [PC_W-1:0]  dpc4;
  logic             dvalid;
  logic [5:0]       op;
  logic [5:0]       func;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [15:0]      imm;
  logic [25:0]      addr;
  logic [31:0]      sa;
  logic             sa_imm;
  logic [PC_W-1:0]  jpc;
  logic [PC_W-1:0]  bpc;
  logic             is_j;
  logic             is_br;
  logic             is_jr;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output pc4, ins, fvalid, wpcir, dflush, cnt_clr,
    input  dpc4, dvalid, op, func, rs, rt, rd, imm, addr, sa, sa_imm,
           jpc, bpc, is_j, is_br, is_jr, stall_cnt, flush_cnt
  );

  modport slave (
    input  pc4, ins, fvalid, wpcir, dflush, cnt_clr,
    output dpc4, dvalid, op, func, rs, rt, rd, imm, addr, sa, sa_imm,
           jpc, bpc, is_j, is_br, is_jr, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_d_stage.sv
// IF/ID pipeline register with stall/flush, field decode and branch/jump targets.
// Define PIPE_D_PERF_EN to build the saturating stall/flush performance counters.
module pipe_d_stage #(
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input logic          clock,
  input logic          resetn,
  pipe_d_stage_if.slave d
);

  logic [PC_W-1:0] dpc4_q;
  logic [31:0]     inst_q;
  logic            dvalid_q;

  // Flush wins over write enable; a flush leaves dpc4 alone so the slot keeps its PC.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dpc4_q   <= '0;
      inst_q   <= NOP_INST;
      dvalid_q <= 1'b0;
    end else if (d.dflush) begin
      inst_q   <= NOP_INST;
      dvalid_q <= 1'b0;
    end else if (d.wpcir) begin
      dpc4_q   <= d.pc4;
      dvalid_q <= d.fvalid;
      inst_q   <= d.fvalid ? d.ins : NOP_INST;
    end
  end

  logic [5:0]      op_w;
  logic [5:0]      func_w;
  logic [15:0]     imm_w;
  logic [25:0]     addr_w;
  logic [PC_W-1:0] br_off;

  assign op_w   = inst_q[31:26];
  assign func_w = inst_q[5:0];
  assign imm_w  = inst_q[15:0];
  assign addr_w = inst_q[25:0];
  assign br_off = {{(PC_W-18){imm_w[15]}}, imm_w, 2'b00};

  assign d.dpc4   = dpc4_q;
  assign d.dvalid = dvalid_q;
  assign d.op     = op_w;
  assign d.func   = func_w;
  assign d.rs     = inst_q[25:21];
  assign d.rt     = inst_q[20:16];
  assign d.rd     = inst_q[15:11];
  assign d.imm    = imm_w;
  assign d.addr   = addr_w;
  assign d.sa     = {27'b0, inst_q[10:6]};
  assign d.sa_imm = (op_w == 6'b000000);
  assign d.bpc    = dpc4_q + br_off;

  generate
    if (PC_W > 28) begin : g_jpc_hi
      assign d.jpc = {dpc4_q[PC_W-1:28], addr_w, 2'b00};
    end else begin : g_jpc_lo
      assign d.jpc = {addr_w, 2'b00};
    end
  endgenerate

  assign d.is_j  = dvalid_q && (op_w == 6'b000010 || op_w == 6'b000011);
  assign d.is_br = dvalid_q && (op_w == 6'b000100 || op_w == 6'b000101);
  assign d.is_jr = dvalid_q && (op_w == 6'b000000) && (func_w == 6'b001000);

`ifdef PIPE_D_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Counters observe the pre-edge dvalid: they count slots actually held or squashed.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (d.cnt_clr) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (dvalid_q && !d.wpcir && !d.dflush && stall_q != CNT_MAX)
        stall_q <= stall_q + 1'b1;
      if (dvalid_q && d.dflush && flush_q != CNT_MAX)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign d.stall_cnt = stall_q;
  assign d.flush_cnt = flush_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = d.cnt_clr;
  assign d.stall_cnt    = '0;
  assign d.flush_cnt    = '0;
`endif

endmodule
